// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: instruction-cache refill controller.
// After reset or a flush, it sweeps every line to invalid. It then services
// one miss at a time: it issues a memory read request, waits for the
// response, and writes the line in a single cycle.
// Optional feature: define ICACHE_REFILL_TIMEOUT_EN to abort a fill when no
// response arrives within 255 WAIT cycles. An aborted fill pulses error and
// writes nothing.
module icache_refill_ctrl #(
  parameter  int CACHE_SIZE = 64,
  parameter  int LINE_SIZE  = 32,
  localparam int IDX_W      = $clog2(CACHE_SIZE),
  localparam int TAG_W      = 32 - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 miss_valid,
  input  logic [31:0]          miss_addr,
  output logic                 miss_ready,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [LINE_SIZE-1:0] mem_rsp_data,
  output logic                 fill_we,
  output logic [IDX_W-1:0]     fill_index,
  output logic [TAG_W-1:0]     fill_tag,
  output logic [LINE_SIZE-1:0] fill_data,
  output logic                 fill_valid,
  output logic                 done,
  output logic                 error,
  output logic                 busy
);

  typedef enum logic [2:0] {INIT, IDLE, REQ, WAIT, WRITE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_SIZE-1:0] data_q, data_d;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // Timeout counter for the WAIT state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  // State and datapath registers. The reset is asynchronous, so every output
  // that is decoded from these registers returns to its reset value at once.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together from the values they held before the clock edge.
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_req_addr = addr_q;
  assign busy         = (state_q != IDLE);

  // Next-state, register-update and output decode.
  always_comb begin
    // NOTE: every signal gets a default value first. Without it, some branch
    // would leave a signal unassigned and synthesis would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    addr_d        = addr_q;
    data_d        = data_q;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    fill_valid    = 1'b0;
    fill_index    = '0;
    fill_tag      = '0;
    fill_data     = '0;
    done          = 1'b0;
    error         = 1'b0;

    unique case (state_q)
      INIT: begin
        // Write one invalid line per cycle, covering indices 0 through CACHE_SIZE-1.
        fill_we    = 1'b1;
        fill_index = cnt_q;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(CACHE_SIZE - 1)) state_d = IDLE;
      end
      IDLE: begin
        // A flush, new or pending, takes priority over any miss.
        if (flush || pend_q) begin
          state_d = INIT;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          miss_ready = 1'b1;
          if (miss_valid) begin
            addr_d  = miss_addr;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (flush) pend_d = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (flush) pend_d = 1'b1;
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = WRITE;
        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
        // The counter is still 254 on the 255th WAIT cycle; abort on that cycle.
        else if (tmo_q == 8'd254) begin
          error   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
`endif
      end
      WRITE: begin
        fill_we    = 1'b1;
        fill_valid = 1'b1;
        fill_index = addr_q[IDX_W-1:0];
        fill_tag   = addr_q[31:IDX_W];
        fill_data  = data_q;
        done       = 1'b1;
        if (flush) pend_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized self-checking bench for icache_refill_ctrl.
// The reference model is the expected cache contents, an array of
// valid/tag/data per line. Per-cycle expectations are computed from the
// transaction parameters with plain arithmetic.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        flush = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        miss_ready, mem_req_valid, fill_we, fill_valid, done, error, busy;
  logic [31:0] mem_req_addr, fill_data;
  logic [5:0]  fill_index;
  logic [25:0] fill_tag;

  int n_vec = 0;
  int n_err = 0;

  // Expected cache contents and the contents actually written by the DUT.
  logic        exp_valid [64];
  logic [25:0] exp_tag   [64];
  logic [31:0] exp_data  [64];
  logic        got_valid [64];
  logic [25:0] got_tag   [64];
  logic [31:0] got_data  [64];
  int          exp_fills = 0;
  int          got_fills = 0;

  icache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .fill_valid(fill_valid),
    .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every write the DUT makes to the cache arrays.
  always @(negedge clk) begin
    #2;
    if (fill_we === 1'b1) begin
      got_valid[fill_index] = fill_valid;
      got_tag[fill_index]   = fill_tag;
      got_data[fill_index]  = fill_data;
      if (fill_valid === 1'b1) got_fills++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_sweep();
    for (int i = 0; i < 64; i++) begin
      exp_valid[i] = 1'b0;
      exp_tag[i]   = '0;
      exp_data[i]  = '0;
    end
  endtask

  // Expects 64 sweep cycles. The caller is already in the index-0 cycle.
  task automatic expect_sweep(input string name);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin tick(); #1; end
      n_vec++;
      if ({fill_we, fill_valid, fill_index, fill_tag, fill_data, miss_ready, mem_req_valid, busy}
          !== {1'b1, 1'b0, 6'(i), 26'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL %s sweep[%0d]: got we=%b v=%b idx=%0d tag=%h data=%h rdy=%b req=%b busy=%b, want we=1 v=0 idx=%0d tag=0 data=0 rdy=0 req=0 busy=1",
                 name, i, fill_we, fill_valid, fill_index, fill_tag, fill_data, miss_ready, mem_req_valid, busy, i);
      end
    end
    model_sweep();
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if ({miss_ready, busy, fill_we, done, error, mem_req_valid} !== 6'b100000) begin
      n_err++;
      $display("FAIL %s idle: got rdy/busy/we/done/err/req=%b want 100000", name,
               {miss_ready, busy, fill_we, done, error, mem_req_valid});
    end
  endtask

  // One complete miss. The request is accepted on the first cycle (an IDLE
  // cycle). mem_req_ready is withheld for req_wait cycles and the response
  // for rsp_wait cycles. flush_phase pulses flush in the first cycle of
  // 1=REQ, 2=WAIT or 3=WRITE; 0 means no flush.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                         input int req_wait, input int rsp_wait, input int flush_phase,
                         input string name);
    tick(); miss_valid = 1'b1; miss_addr = addr; #1;
    n_vec++;
    if ({miss_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL %s accept: got rdy/busy=%b want 10", name, {miss_ready, busy});
    end
    for (int k = 0; k <= req_wait; k++) begin
      tick();
      miss_valid    = 1'b0;
      miss_addr     = $urandom;
      mem_req_ready = (k == req_wait);
      flush         = (flush_phase == 1 && k == 0);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      #1;
      n_vec++;
      if ({mem_req_valid, mem_req_addr, fill_we, done, miss_ready} !== {1'b1, addr, 3'b000}) begin
        n_err++;
        $display("FAIL %s req[%0d]: got req=%b addr=%h we=%b done=%b rdy=%b want req=1 addr=%h we=0 done=0 rdy=0",
                 name, k, mem_req_valid, mem_req_addr, fill_we, done, miss_ready, addr);
      end
    end
    for (int k = 0; k <= rsp_wait; k++) begin
      tick();
      mem_req_ready = 1'($urandom_range(0, 1));
      flush         = (flush_phase == 2 && k == 0);
      mem_rsp_valid = (k == rsp_wait);
      mem_rsp_data  = (k == rsp_wait) ? data : $urandom;
      #1;
      n_vec++;
      if ({mem_req_valid, fill_we, done, error, busy} !== 5'b00001) begin
        n_err++;
        $display("FAIL %s wait[%0d]: got req/we/done/err/busy=%b want 00001", name, k,
                 {mem_req_valid, fill_we, done, error, busy});
      end
    end
    // WRITE cycle. The stray response with inverted data must be ignored.
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = ~data;
    flush         = (flush_phase == 3);
    #1;
    n_vec++;
    if ({fill_we, fill_valid, fill_index, fill_tag, fill_data, done, mem_req_valid, error}
        !== {2'b11, addr[5:0], addr[31:6], data, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s write done@N+%0d: got we=%b v=%b idx=%h tag=%h data=%h done=%b want we=1 v=1 idx=%h tag=%h data=%h done=1",
               name, req_wait + rsp_wait + 3, fill_we, fill_valid, fill_index, fill_tag, fill_data, done,
               addr[5:0], addr[31:6], data);
    end
    exp_valid[addr[5:0]] = 1'b1;
    exp_tag[addr[5:0]]   = addr[31:6];
    exp_data[addr[5:0]]  = data;
    exp_fills++;
    tick();
    mem_rsp_valid = 1'b0;
    flush         = 1'b0;
    miss_valid    = (flush_phase != 0);
    miss_addr     = $urandom;
    #1;
    if (flush_phase == 0) begin
      check_idle(name);
    end else begin
      n_vec++;
      if ({miss_ready, busy, fill_we, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL %s pending-flush idle: got rdy/busy/we/done=%b want 0000", name,
                 {miss_ready, busy, fill_we, done});
      end
      tick(); #1;
      expect_sweep({name, "-flush"});
      miss_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({miss_ready, mem_req_valid, done, error, fill_valid, busy, mem_req_addr} !== {6'b000001, 32'd0}) begin
      n_err++;
      $display("FAIL reset: got rdy/req/done/err/v/busy=%b addr=%h want 000001 addr=0",
               {miss_ready, mem_req_valid, done, error, fill_valid, busy}, mem_req_addr);
    end
    tick(); tick(); tick();
    reset_n = 1'b1;
    #1;
    expect_sweep("post-reset");
    tick(); #1;
    check_idle("post-reset");
  endtask

  task automatic test_directed();
    do_miss(32'h0000_1044, 32'hDEAD_BEEF, 0, 0, 0, "min-latency");
    do_miss($urandom, $urandom, 5, 0, 0, "req-stall5");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      do_miss($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4), 0, "random");
    for (int ph = 1; ph <= 3; ph++)
      do_miss($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), ph, "flush-mid-fill");
    do_miss($urandom, $urandom, 1, 2, 0, "after-flush");
  endtask

  task automatic test_flush_idle();
    logic [31:0] a;
    a = $urandom;
    tick(); miss_valid = 1'b1; miss_addr = a; flush = 1'b1; #1;
    n_vec++;
    if (miss_ready !== 1'b0) begin
      n_err++; $display("FAIL flush-vs-miss: got miss_ready=%b want 0", miss_ready);
    end
    tick(); flush = 1'b0; #1;
    expect_sweep("flush-idle");
    do_miss(a, $urandom, 0, 1, 0, "miss-after-sweep");
  endtask

  task automatic test_reset_mid_fill();
    tick(); miss_valid = 1'b1; miss_addr = $urandom; #1;
    tick(); miss_valid = 1'b0; mem_req_ready = 1'b1; #1;
    tick(); mem_req_ready = 1'b0; #2;
    // Reset asserted between clock edges: outputs must change without a clock.
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({miss_ready, mem_req_valid, done, error, fill_valid, busy, mem_req_addr} !== {6'b000001, 32'd0}) begin
      n_err++;
      $display("FAIL reset-in-wait: got rdy/req/done/err/v/busy=%b addr=%h want 000001 addr=0",
               {miss_ready, mem_req_valid, done, error, fill_valid, busy}, mem_req_addr);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
    tick(); tick();
    reset_n = 1'b1; mem_rsp_valid = 1'b0;
    #1;
    expect_sweep("reset-in-wait");
    tick(); #1;
    check_idle("reset-in-wait");
  endtask

`ifdef ICACHE_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    tick(); miss_valid = 1'b1; miss_addr = $urandom; #1;
    tick(); miss_valid = 1'b0; mem_req_ready = 1'b1; #1;
    for (int k = 1; k <= 255; k++) begin
      tick(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; #1;
      n_vec++;
      if ({error, fill_we, busy} !== {(k == 255), 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL timeout wait[%0d]: got err/we/busy=%b want %b", k,
                 {error, fill_we, busy}, {(k == 255), 2'b01});
      end
    end
    tick(); mem_rsp_valid = 1'b1; mem_rsp_data = $urandom; #1;
    check_idle("late-rsp");
    tick(); mem_rsp_valid = 1'b0; #1;
    check_idle("after-timeout");
  endtask
`else
  task automatic test_long_wait();
    do_miss($urandom, $urandom, 0, 300, 0, "long-wait");
  endtask
`endif

  task automatic test_contents();
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if ({got_valid[i], got_tag[i], got_data[i]} !== {exp_valid[i], exp_tag[i], exp_data[i]}) begin
        n_err++;
        $display("FAIL contents[%0d]: got v=%b tag=%h data=%h want v=%b tag=%h data=%h", i,
                 got_valid[i], got_tag[i], got_data[i], exp_valid[i], exp_tag[i], exp_data[i]);
      end
    end
    n_vec++;
    if (got_fills != exp_fills) begin
      n_err++; $display("FAIL fill-count: got %0d want %0d", got_fills, exp_fills);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      got_valid[i] = 1'b0; got_tag[i] = '0; got_data[i] = '0;
    end
    model_sweep();
    test_reset();
    test_directed();
    test_random();
    test_flush_idle();
`ifdef ICACHE_REFILL_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_fill();
    do_miss($urandom, $urandom, 0, 0, 0, "after-reset");
    tick(); tick();
    test_contents();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter CACHE_SIZE, 64, number of cache lines (index = addr[5:0]).
REQ-002 Parameter LINE_SIZE, 32, data bits per line.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 miss_valid  input  1  lookup side reports a miss.
REQ-006 miss_addr  input  32  missing address.
REQ-007 miss_ready  output  1  controller accepts a miss this cycle.
REQ-008 flush  input  1  request to invalidate all lines.
REQ-009 mem_req_valid / mem_req_ready  output / input  1 / 1  memory read-request handshake.
REQ-010 mem_req_addr  output  32  read address, equal to the latched miss_addr.
REQ-011 mem_rsp_valid / mem_rsp_data  input / input  1 / 32  memory read response.
REQ-012 fill_we  output  1  write strobe to cache data, tag and valid arrays.
REQ-013 fill_index / fill_tag / fill_data / fill_valid  output  6 / 26 / 32 / 1  line write payload.
REQ-014 done / error  output  1 / 1  single-cycle pulses: fill complete / fill aborted.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be INIT, IDLE, REQ, WAIT and WRITE.
REQ-017 INIT: 6-bit sweep counter 0..63; each cycle fill_we=1, fill_valid=0, fill_tag=0, fill_data=0, fill_index=counter; after index 63 -> IDLE (exactly 64 cycles).
REQ-018 IDLE: miss_ready=1 unless flush or a pending flush is set; miss_valid&&miss_ready latches miss_addr -> REQ.
REQ-019 flush in IDLE -> INIT, counter cleared; flush wins over a simultaneous miss_valid (miss_ready=0 that cycle).
REQ-020 flush in REQ/WAIT/WRITE SHALL set a pending flag; the current fill completes, then IDLE -> INIT on the next cycle with no miss accepted.
REQ-021 REQ: mem_req_valid=1, mem_req_addr stable until mem_req_ready; on handshake -> WAIT.
REQ-022 WAIT: on mem_rsp_valid latch mem_rsp_data -> WRITE; mem_rsp_valid outside WAIT is ignored.
REQ-023 WRITE: one cycle with fill_we=1, fill_valid=1, fill_index=addr[5:0], fill_tag=addr[31:6], fill_data=latched data, done=1 -> IDLE.
REQ-024 Minimum miss-to-done latency (ready and response immediate): accept cycle N, mem_req_valid N+1, response N+2, done N+3.
REQ-025 fill_we SHALL be 0 in IDLE, REQ and WAIT; mem_req_valid 0 outside REQ.

Reset
REQ-026 reset_n low SHALL immediately force INIT, counter 0, pending flush 0, latched address/data 0, mem_req_valid 0, done 0, error 0, miss_ready 0.
REQ-027 Reset asserted mid-fill SHALL abandon the fill without fill_we=1 for it; sweep restarts at index 0 after release.

Configuration
REQ-028 Macro ICACHE_REFILL_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry; if no mem_rsp_valid within 255 WAIT cycles, error=1 for one cycle, no fill, -> IDLE; a later response is ignored.
REQ-029 Macro undefined: WAIT holds indefinitely; error tied 0; no timeout counter.

Verification
REQ-030 Release reset -> fill_we=1, fill_valid=0 for 64 cycles, indices 0..63 in order, then miss_ready=1.
REQ-031 Miss addr 0x0000_1044, ready/response immediate, data 0xDEAD_BEEF -> one fill_we, index 0x04, tag 0x41, data 0xDEAD_BEEF, done 3 cycles after accept.
REQ-032 mem_req_ready held low 5 cycles -> mem_req_valid and addr stable all 5 cycles; single handshake.
REQ-033 flush and miss_valid same IDLE cycle -> miss not accepted, 64-cycle sweep, then miss accepted; flush during WAIT -> fill done first, then sweep.
REQ-034 With ICACHE_REFILL_TIMEOUT_EN, no response -> error pulse after 255 WAIT cycles, no fill_we=1, late response ignored.
REQ-035 reset_n low during WAIT -> outputs at reset values immediately; new sweep from index 0.
